// File: rtl/vga_console_ctrl.sv
// Console write-port controller for the 80x30 text buffer: turns a byte stream into cell
// writes, tracks the cursor, handles CR/LF/BS/FF and sequences screen and row clears.
module vga_console_ctrl #(
  parameter int         COLS  = 80,
  parameter int         ROWS  = 30,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ch_valid,
  input  logic [7:0]  ch_data,
  output logic        ch_ready,
  input  logic        dir_wen,
  input  logic [11:0] dir_addr,
  input  logic [7:0]  dir_data,
  output logic        wen,
  output logic [11:0] w_addr,
  output logic [7:0]  w_data,
  output logic [6:0]  cur_col,
  output logic [4:0]  cur_row,
  output logic        busy
);

  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_CLR_ALL = 2'd1;
  localparam logic [1:0]  S_CLR_ROW = 2'd2;
  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
  localparam logic [11:0] LAST_ALL  = 12'(COLS * ROWS - 1);
  localparam logic [11:0] LAST_ROWC = 12'(COLS - 1);

  logic [1:0]  state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic        wen_q, wen_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [4:0]  row_adv;

  function automatic logic [11:0] cell_addr(input logic [4:0] r, input logic [6:0] c);
    return 12'(r) * 12'(COLS) + 12'(c);
  endfunction

  assign row_adv  = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
  assign ch_ready = (state_q == S_IDLE) && !dir_wen;
  assign busy     = (state_q != S_IDLE);
  assign wen      = wen_q;
  assign w_addr   = addr_q;
  assign w_data   = data_q;
  assign cur_col  = col_q;
  assign cur_row  = row_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    wen_d   = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    // The direct port owns the bus; any sweep simply holds its counter this cycle.
    if (dir_wen) begin
      wen_d  = 1'b1;
      addr_d = dir_addr;
      data_d = dir_data;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ch_valid) begin
            if (ch_data >= 8'h20) begin
              wen_d  = 1'b1;
              addr_d = cell_addr(row_q, col_q);
              data_d = ch_data;
              if (col_q == LAST_COL) begin
                col_d   = 7'd0;
                row_d   = row_adv;
                cnt_d   = 12'd0;
                state_d = S_CLR_ROW;
              end else begin
                col_d = col_q + 7'd1;
              end
            end else begin
              case (ch_data)
                8'h0A: begin
                  // No char write competes here, so the first clear cell goes out now.
                  col_d   = 7'd0;
                  row_d   = row_adv;
                  wen_d   = 1'b1;
                  addr_d  = cell_addr(row_adv, 7'd0);
                  data_d  = BLANK;
                  cnt_d   = 12'd1;
                  state_d = S_CLR_ROW;
                end
                8'h0D: col_d = 7'd0;
                8'h08: begin
                  if (col_q != 7'd0) begin
                    col_d  = col_q - 7'd1;
                    wen_d  = 1'b1;
                    addr_d = cell_addr(row_q, col_q - 7'd1);
                    data_d = BLANK;
                  end
                end
                8'h0C: begin
                  col_d   = 7'd0;
                  row_d   = 5'd0;
                  wen_d   = 1'b1;
                  addr_d  = 12'd0;
                  data_d  = BLANK;
                  cnt_d   = 12'd1;
                  state_d = S_CLR_ALL;
                end
                default: ;
              endcase
            end
          end
        end
        S_CLR_ROW: begin
          wen_d  = 1'b1;
          addr_d = cell_addr(row_q, 7'd0) + cnt_q;
          data_d = BLANK;
          if (cnt_q == LAST_ROWC) state_d = S_IDLE;
          else                    cnt_d   = cnt_q + 12'd1;
        end
        S_CLR_ALL: begin
          wen_d  = 1'b1;
          addr_d = cnt_q;
          data_d = BLANK;
          if (cnt_q == LAST_ALL) state_d = S_IDLE;
          else                   cnt_d   = cnt_q + 12'd1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLR_ALL;
      cnt_q   <= 12'd0;
      col_q   <= 7'd0;
      row_q   <= 5'd0;
      wen_q   <= 1'b0;
      addr_q  <= 12'd0;
      data_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_vga_console_ctrl.sv
// Directed bench for vga_console_ctrl: clears, printables, control codes, direct-write priority.
module tb_vga_console_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ch_valid = 1'b0;
  logic [7:0]  ch_data = 8'h00;
  logic        ch_ready;
  logic        dir_wen = 1'b0;
  logic [11:0] dir_addr = 12'h000;
  logic [7:0]  dir_data = 8'h00;
  logic        wen;
  logic [11:0] w_addr;
  logic [7:0]  w_data;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  vga_console_ctrl dut (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
    .dir_wen(dir_wen), .dir_addr(dir_addr), .dir_data(dir_data),
    .wen(wen), .w_addr(w_addr), .w_data(w_data),
    .cur_col(cur_col), .cur_row(cur_row), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    ch_valid = 1'b1;
    ch_data  = b;
    tick();
    ch_valid = 1'b0;
  endtask

  // Entered in the cycle the first clear write should be on the bus.
  task automatic sweep_check(input string tag, input int base, input int n);
    int bad_bus = 0;
    int bad_rdy = 0;
    for (int i = 0; i < n; i++) begin
      if (wen !== 1'b1 || w_addr !== 12'(base + i) || w_data !== 8'h20) bad_bus++;
      if (ch_ready !== ((i == n - 1) ? 1'b1 : 1'b0)) bad_rdy++;
      tick();
    end
    check({tag, "_bus"}, bad_bus, 0);
    check({tag, "_rdy"}, bad_rdy, 0);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int k = 0;
    while (ch_ready !== 1'b1 && k < limit) begin
      tick();
      k++;
    end
    if (ch_ready !== 1'b1) check({tag, "_timeout"}, ch_ready, 1);
  endtask

  initial begin
    int bad;
    int addr_e;
    int data_e;
    int clr_idx;

    // Reset state
    tick();
    tick();
    check("rst_wen", wen, 0);
    check("rst_addr", w_addr, 0);
    check("rst_data", w_data, 0);
    check("rst_busy", busy, 1);
    check("rst_ready", ch_ready, 0);
    check("rst_cursor", {cur_row, cur_col}, 0);
    rst = 1'b0;
    tick();
    sweep_check("rst_sweep", 0, 2400);
    check("idle_wen", wen, 0);
    check("idle_cursor", {cur_row, cur_col}, 0);

    // "AB" back-to-back
    send(8'h41);
    check("A_wr", {wen, w_addr, w_data}, {1'b1, 12'd0, 8'h41});
    send(8'h42);
    check("B_wr", {wen, w_addr, w_data}, {1'b1, 12'd1, 8'h42});
    check("AB_col", cur_col, 2);

    // CR, BS at col 0
    send(8'h0D);
    check("CR_col", cur_col, 0);
    check("CR_nowr", wen, 0);
    send(8'h08);
    check("BS0_col", cur_col, 0);
    check("BS0_nowr", wen, 0);

    // LF to row 1 and its clear
    send(8'h0A);
    check("LF_cursor", {cur_row, cur_col}, {5'd1, 7'd0});
    sweep_check("LF_sweep", 80, 80);

    // Five printables then BS at col 5
    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
    check("e_wr", {wen, w_addr, w_data}, {1'b1, 12'd84, 8'h65});
    check("e_col", cur_col, 5);
    send(8'h08);
    check("BS5_wr", {wen, w_addr, w_data}, {1'b1, 12'd84, 8'h20});
    check("BS5_col", cur_col, 4);
    send(8'h01);
    check("ign_nowr", wen, 0);
    check("ign_col", cur_col, 4);

    // Direct write colliding with a character offer
    ch_valid = 1'b1;
    ch_data  = 8'h58;
    dir_wen  = 1'b1;
    dir_addr = 12'hABC;
    dir_data = 8'h5A;
    #1;
    check("coll_ready", ch_ready, 0);
    tick();
    ch_valid = 1'b0;
    dir_wen  = 1'b0;
    check("dir_wr", {wen, w_addr, w_data}, {1'b1, 12'hABC, 8'h5A});
    check("coll_col", cur_col, 4);

    // Row clear (row 2, cells 160..239) with dir_wen held three cycles
    send(8'h0A);
    bad = 0;
    for (int c = 1; c <= 83; c++) begin
      if (c >= 11 && c <= 13) begin
        addr_e = 32'h900 + c - 1;
        data_e = 32'hC0 + c - 1;
      end else begin
        clr_idx = (c <= 10) ? c - 1 : c - 4;
        addr_e  = 160 + clr_idx;
        data_e  = 32'h20;
      end
      if (wen !== 1'b1 || w_addr !== 12'(addr_e) || w_data !== 8'(data_e)) bad++;
      dir_wen  = (c >= 10 && c <= 12);
      dir_addr = 12'(32'h900 + c);
      dir_data = 8'(32'hC0 + c);
      #1;
      if (ch_ready !== ((c == 83) ? 1'b1 : 1'b0)) bad++;
      tick();
    end
    dir_wen = 1'b0;
    check("dirsweep", bad, 0);
    check("dirsweep_done", wen, 0);

    // Walk down to row 29
    for (int k = 0; k < 27; k++) begin
      send(8'h0A);
      wait_idle("lf_walk", 200);
    end
    check("row29", {cur_row, cur_col}, {5'd29, 7'd0});

    // 80 printables on the last row, then wrap to row 0
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      send(8'h30 + 8'(i));
      if (wen !== 1'b1 || w_addr !== 12'(2320 + i) || w_data !== 8'(8'h30 + 8'(i))) bad++;
    end
    check("row29_wr", bad, 0);
    check("last_addr", w_addr, 2399);
    check("wrap_cursor", {cur_row, cur_col}, 0);
    tick();
    sweep_check("wrap_sweep", 0, 80);

    // Reset pulsed at cell 40 of a row clear
    send(8'h0A);
    for (int i = 0; i < 40; i++) tick();
    check("mid_addr", w_addr, 120);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_wen", wen, 0);
    check("rst2_busy", busy, 1);
    check("rst2_cursor", {cur_row, cur_col}, 0);
    tick();
    sweep_check("rst2_sweep", 0, 2400);

    // FF from a nonzero cursor
    send(8'h5A);
    check("Z_col", cur_col, 1);
    send(8'h0C);
    check("FF_cursor", {cur_row, cur_col}, 0);
    sweep_check("FF_sweep", 0, 2400);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
